// File: rtl/redmule_tcdm_gather.sv
// Lane-coherence stage: folds per-lane TCDM grants into one atomic upstream grant and
// releases responses only when every lane holds data. Optional: REDMULE_TCDM_GATHER_BYPASS_EN.
module redmule_tcdm_gather #(
    parameter  int unsigned MP    = 4,
    parameter  int unsigned DW    = 256,
    parameter  int unsigned AW    = 32,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned LW    = DW / MP
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic [MP-1:0]            in_req_i,
    output logic [MP-1:0]            in_gnt_o,
    input  logic [MP-1:0][AW-1:0]    in_add_i,
    input  logic [MP-1:0]            in_wen_i,
    input  logic [MP-1:0][LW/8-1:0]  in_be_i,
    input  logic [MP-1:0][LW-1:0]    in_data_i,
    output logic [MP-1:0][LW-1:0]    in_r_data_o,
    output logic [MP-1:0]            in_r_valid_o,
    output logic [MP-1:0]            out_req_o,
    input  logic [MP-1:0]            out_gnt_i,
    output logic [MP-1:0][AW-1:0]    out_add_o,
    output logic [MP-1:0]            out_wen_o,
    output logic [MP-1:0][LW/8-1:0]  out_be_o,
    output logic [MP-1:0][LW-1:0]    out_data_o,
    input  logic [MP-1:0][LW-1:0]    out_r_data_i,
    input  logic [MP-1:0]            out_r_valid_i,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [MP-1:0] granted_q, lane_gnt, lane_done;
    logic [MP-1:0] empty, avail, bypass, ovf;
    logic [CW-1:0] outstanding_q;
    logic          credit, up_gnt, rel, dec, proto_err, err_q;

    // Pointers carry a wrap bit so full/empty stay distinguishable for any DEPTH.
    function automatic logic [PW:0] ptr_inc(input logic [PW:0] p);
        if (p[PW-1:0] == PW'(DEPTH - 1)) return {~p[PW], {PW{1'b0}}};
        return p + (PW+1)'(1);
    endfunction

    assign credit    = (outstanding_q < CW'(DEPTH));
    assign out_req_o = in_req_i & ~granted_q & {MP{credit}};
    assign lane_gnt  = out_req_o & out_gnt_i;
    assign lane_done = granted_q | lane_gnt;
    assign up_gnt    = (&in_req_i) & credit & (&lane_done);
    assign in_gnt_o  = {MP{up_gnt}};

    assign out_add_o  = in_add_i;
    assign out_wen_o  = in_wen_i;
    assign out_be_o   = in_be_i;
    assign out_data_o = in_data_i;

    assign rel          = &avail;
    assign in_r_valid_o = {MP{rel}};
    assign dec          = rel & (outstanding_q != '0);

    // A partial grant requires all request bits to stay high; unequal bits imply a drop.
    assign proto_err = (|ovf) | ((|granted_q) & ~(&in_req_i));

    assign busy_o = (outstanding_q != '0) | (|granted_q);
    assign err_o  = err_q;

    for (genvar l = 0; l < MP; l++) begin : g_lane
        logic [PW:0]   wptr_q, rptr_q;
        logic [LW-1:0] mem_q [DEPTH];
        logic          full, push;

        assign empty[l] = (wptr_q == rptr_q);
        assign full     = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
`ifdef REDMULE_TCDM_GATHER_BYPASS_EN
        assign bypass[l] = empty[l] & out_r_valid_i[l];
`else
        assign bypass[l] = 1'b0;
`endif
        assign avail[l]       = ~empty[l] | bypass[l];
        assign in_r_data_o[l] = bypass[l] ? out_r_data_i[l] : mem_q[rptr_q[PW-1:0]];
        // A full lane still accepts a push when its head is popped in the same cycle.
        assign push   = out_r_valid_i[l] & ~(bypass[l] & rel) & (~full | rel);
        assign ovf[l] = out_r_valid_i[l] & full & ~rel;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wptr_q <= '0;
                rptr_q <= '0;
                for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            end else if (clear_i) begin
                wptr_q <= '0;
                rptr_q <= '0;
                for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            end else begin
                if (push) begin
                    mem_q[wptr_q[PW-1:0]] <= out_r_data_i[l];
                    wptr_q <= ptr_inc(wptr_q);
                end
                if (rel && !bypass[l]) rptr_q <= ptr_inc(rptr_q);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            granted_q     <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else if (clear_i) begin
            granted_q     <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            granted_q <= up_gnt ? '0 : (granted_q | lane_gnt);
            if (up_gnt && !dec)      outstanding_q <= outstanding_q + CW'(1);
            else if (!up_gnt && dec) outstanding_q <= outstanding_q - CW'(1);
            if (proto_err) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_redmule_tcdm_gather.sv
// Bench for redmule_tcdm_gather: cycle table, directed corner sequences and a
// randomized run against a queue-based lane model.
module tb_redmule_tcdm_gather;
    localparam int MP = 4, DW = 256, AW = 32, DEPTH = 2, LW = 64;
`ifdef REDMULE_TCDM_GATHER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0, rst_ni = 1'b0, clear_i = 1'b0;
    logic [3:0] in_req, in_gnt, in_wen, in_rv, out_req, out_gnt, out_wen, out_rv;
    logic [3:0][31:0] in_add, out_add;
    logic [3:0][7:0]  in_be, out_be;
    logic [3:0][63:0] in_data, out_data, in_rdata, out_rdata;
    logic busy, err;

    int n_chk = 0, n_pass = 0;

    redmule_tcdm_gather #(.MP(MP), .DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
        .in_req_i(in_req), .in_gnt_o(in_gnt), .in_add_i(in_add), .in_wen_i(in_wen),
        .in_be_i(in_be), .in_data_i(in_data), .in_r_data_o(in_rdata), .in_r_valid_o(in_rv),
        .out_req_o(out_req), .out_gnt_i(out_gnt), .out_add_o(out_add), .out_wen_o(out_wen),
        .out_be_o(out_be), .out_data_o(out_data), .out_r_data_i(out_rdata),
        .out_r_valid_i(out_rv), .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask
    task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
        chk(nm, 256'(act), 256'(exp));
    endtask
    task automatic drv(input logic [3:0] req, input logic [3:0] gnt, input logic [3:0] rv);
        in_req = req; out_gnt = gnt; out_rv = rv;
    endtask
    task automatic nxt;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [3:0] req, gnt, rv, e_oreq, e_gnt, e_rv;
        logic       e_busy;
    } vec_t;
    vec_t tv[13];

    // model state
    logic [63:0] q[4][$];
    int          pend[4];
    logic [3:0]  mg;
    int          mo;
    bit          want;

    initial begin
        logic [255:0] align, pat;
        logic [3:0]   e_oreq, done, e_gnt, avail;
        logic [255:0] e_data;
        bit           rel, was_empty[4];

        align = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        tv[0]  = '{4'hF, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 1'b0};
        tv[1]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1};
        tv[2]  = '{4'h0, 4'h0, 4'hF, 4'h0, 4'h0, BYP ? 4'hF : 4'h0, 1'b1};
        tv[3]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, BYP ? 4'h0 : 4'hF, !BYP};
        tv[4]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        tv[5]  = '{4'hF, 4'h7, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0};
        tv[6]  = '{4'hF, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 1'b1};
        tv[7]  = '{4'hF, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 1'b1};
        tv[8]  = '{4'hF, 4'h8, 4'h0, 4'h8, 4'hF, 4'h0, 1'b1};
        tv[9]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1};
        tv[10] = '{4'h0, 4'h0, 4'hF, 4'h0, 4'h0, BYP ? 4'hF : 4'h0, 1'b1};
        tv[11] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, BYP ? 4'h0 : 4'hF, !BYP};
        tv[12] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};

        drv(4'h0, 4'h0, 4'h0);
        in_add = '0; in_wen = '0; in_be = '0; in_data = '0; out_rdata = align;
        #3;
        chk4("rst_in_gnt", in_gnt, 4'h0);
        chk4("rst_out_req", out_req, 4'h0);
        chk4("rst_r_valid", in_rv, 4'h0);
        chk("rst_busy_err", 256'({busy, err}), 256'(0));
        chk("rst_r_data", in_rdata, 256'(0));
        @(posedge clk); #1; rst_ni = 1'b1;

        // aligned read + straggler grant
        for (int i = 0; i < 13; i++) begin
            drv(tv[i].req, tv[i].gnt, tv[i].rv);
            @(negedge clk);
            chk4($sformatf("tbl%0d_out_req", i), out_req, tv[i].e_oreq);
            chk4($sformatf("tbl%0d_in_gnt", i), in_gnt, tv[i].e_gnt);
            chk4($sformatf("tbl%0d_r_valid", i), in_rv, tv[i].e_rv);
            chk($sformatf("tbl%0d_busy", i), 256'(busy), 256'(tv[i].e_busy));
            if (tv[i].e_rv != 4'h0) chk($sformatf("tbl%0d_r_data", i), in_rdata, align);
            nxt();
        end

        // skewed responses: lane 1 answers 5 cycles after the others
        pat = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        out_rdata = pat;
        drv(4'hF, 4'hF, 4'h0); @(negedge clk); chk4("skew_gnt", in_gnt, 4'hF); nxt();
        drv(4'h0, 4'h0, 4'b1101); @(negedge clk); chk4("skew_rv_k1", in_rv, 4'h0); nxt();
        for (int k = 2; k < 6; k++) begin
            drv(4'h0, 4'h0, 4'h0); @(negedge clk); chk4($sformatf("skew_rv_k%0d", k), in_rv, 4'h0); nxt();
        end
        drv(4'h0, 4'h0, 4'b0010); @(negedge clk);
        chk4("skew_rv_k6", in_rv, BYP ? 4'hF : 4'h0);
        if (BYP) chk("skew_data", in_rdata, pat);
        nxt();
        drv(4'h0, 4'h0, 4'h0); @(negedge clk);
        chk4("skew_rv_k7", in_rv, BYP ? 4'h0 : 4'hF);
        if (!BYP) chk("skew_data", in_rdata, pat);
        nxt();
        @(negedge clk); chk4("skew_rv_k8", in_rv, 4'h0); chk("skew_idle", 256'(busy), 256'(0)); nxt();

        // credit limit
        drv(4'hF, 4'hF, 4'h0); @(negedge clk); chk4("cred_gnt0", in_gnt, 4'hF); nxt();
        @(negedge clk); chk4("cred_gnt1", in_gnt, 4'hF); nxt();
        @(negedge clk); chk4("cred_full_req", out_req, 4'h0); chk4("cred_full_gnt", in_gnt, 4'h0); nxt();
        drv(4'hF, 4'hF, 4'hF); @(negedge clk); chk4("cred_rsp_req", out_req, 4'h0); nxt();
        drv(4'hF, 4'hF, 4'h0); @(negedge clk);
        chk4("cred_gnt4", in_gnt, BYP ? 4'hF : 4'h0);
        chk4("cred_rv4", in_rv, BYP ? 4'h0 : 4'hF);
        nxt();
        if (!BYP) begin
            @(negedge clk); chk4("cred_gnt5", in_gnt, 4'hF); nxt();
        end
        drv(4'h0, 4'h0, 4'hF); nxt(); nxt();
        drv(4'h0, 4'h0, 4'h0); nxt();
        @(negedge clk); chk("cred_drained", 256'({busy, err}), 256'(0)); nxt();

        // protocol error, sticky until clear
        drv(4'hF, 4'h1, 4'h0); @(negedge clk); chk4("err_partial_gnt", in_gnt, 4'h0); nxt();
        drv(4'h0, 4'h0, 4'h0); @(negedge clk); chk("err_before", 256'(err), 256'(0)); nxt();
        @(negedge clk); chk("err_set", 256'(err), 256'(1)); chk("err_busy", 256'(busy), 256'(1)); nxt();
        @(negedge clk); chk("err_sticky", 256'(err), 256'(1)); clear_i = 1'b1; nxt();
        clear_i = 1'b0;
        @(negedge clk); chk("err_cleared", 256'({busy, err}), 256'(0)); nxt();

        // async reset with an outstanding transaction and a partial grant
        drv(4'hF, 4'hF, 4'h0); @(negedge clk); chk4("ar_gnt", in_gnt, 4'hF); nxt();
        out_rdata = ~align;
        drv(4'hF, 4'h3, 4'h5); @(negedge clk); chk4("ar_req", out_req, 4'hF); nxt();
        drv(4'hF, 4'h0, 4'h0); @(negedge clk); chk4("ar_partial", out_req, 4'hC);
        rst_ni = 1'b0; drv(4'h0, 4'h0, 4'h0); #1;
        chk4("ar_in_gnt", in_gnt, 4'h0);
        chk4("ar_out_req", out_req, 4'h0);
        chk4("ar_rv", in_rv, 4'h0);
        chk("ar_busy_err", 256'({busy, err}), 256'(0));
        chk("ar_r_data", in_rdata, 256'(0));
        @(posedge clk); #1; rst_ni = 1'b1;
        out_rdata = align;
        drv(4'hF, 4'hF, 4'h0); @(negedge clk); chk4("ar_fresh_gnt", in_gnt, 4'hF); nxt();
        drv(4'h0, 4'h0, 4'hF); @(negedge clk);
        chk4("ar_fresh_rv1", in_rv, BYP ? 4'hF : 4'h0);
        if (BYP) chk("ar_fresh_data", in_rdata, align);
        nxt();
        drv(4'h0, 4'h0, 4'h0); @(negedge clk);
        chk4("ar_fresh_rv2", in_rv, BYP ? 4'h0 : 4'hF);
        if (!BYP) chk("ar_fresh_data", in_rdata, align);
        nxt();
        @(negedge clk); chk("ar_fresh_idle", 256'(busy), 256'(0)); nxt();

        // randomized run against the lane model
        mg = '0; mo = 0; want = 0;
        for (int l = 0; l < 4; l++) pend[l] = 0;
        for (int c = 0; c < 600; c++) begin
            if (!want && $urandom_range(0, 2) != 0) want = 1;
            in_req  = want ? 4'hF : 4'h0;
            out_gnt = 4'($urandom);
            for (int l = 0; l < 4; l++) begin
                out_rdata[l] = {$urandom, $urandom};
                out_rv[l] = (pend[l] > 0) && ($urandom_range(0, 2) == 0);
                in_add[l] = $urandom;
                in_data[l] = {$urandom, $urandom};
            end
            @(negedge clk);
            e_oreq = (mo < DEPTH) ? (in_req & ~mg) : 4'h0;
            done   = mg | (e_oreq & out_gnt);
            e_gnt  = (in_req == 4'hF && mo < DEPTH && done == 4'hF) ? 4'hF : 4'h0;
            for (int l = 0; l < 4; l++) begin
                was_empty[l] = (q[l].size() == 0);
                avail[l] = !was_empty[l] || (BYP && out_rv[l]);
                e_data[l*64 +: 64] = was_empty[l] ? out_rdata[l] : q[l][0];
            end
            rel = (avail == 4'hF);
            chk4("rnd_out_req", out_req, e_oreq);
            chk4("rnd_in_gnt", in_gnt, e_gnt);
            chk4("rnd_r_valid", in_rv, rel ? 4'hF : 4'h0);
            if (rel) chk("rnd_r_data", in_rdata, e_data);
            chk("rnd_busy_err", 256'({busy, err}), 256'({(mo != 0 || mg != 0), 1'b0}));
            chk("rnd_pass", 256'({out_add, out_data}), 256'({in_add, in_data}));
            for (int l = 0; l < 4; l++) begin
                if (e_oreq[l] && out_gnt[l]) pend[l]++;
                if (out_rv[l]) pend[l]--;
                if (rel && !was_empty[l]) void'(q[l].pop_front());
                if (out_rv[l] && !(BYP && was_empty[l] && rel)) q[l].push_back(out_rdata[l]);
            end
            if (rel) mo--;
            if (e_gnt != 0) begin
                mg = '0; mo++; want = 0;
            end else begin
                mg = mg | (e_oreq & out_gnt);
            end
            nxt();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
